// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests, buffers responses in a prefetch FIFO.
// Optional feature macro IFU_ALIGN_CHECK_EN: misaligned redirects enter FAULT and deliver one fault entry.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a redirect in the same cycle cancels issue and pop.
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1
`ifdef IFU_ALIGN_CHECK_EN
    , ST_FAULT = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_cnt_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW-1:0] pend_rd_q, pend_wr_q;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pend_pc  [DEPTH];
`ifdef IFU_ALIGN_CHECK_EN
  logic          fault_mem [DEPTH];
`endif

  logic          accept, rsp_keep, rsp_drop, pop, fault_redirect;
  logic [CW+1:0] credit_sum;
  logic          fifo_we;
  logic [AW-1:0] fifo_waddr;
  logic [31:0]   fifo_wpc, fifo_wdata;

`ifdef IFU_ALIGN_CHECK_EN
  assign fault_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign fault_redirect = 1'b0;
`endif

  // Every outstanding request reserves a FIFO slot, so the FIFO can never overflow.
  assign credit_sum     = (CW+2)'(fifo_cnt_q) + (CW+2)'(live_q) + (CW+2)'(drop_q);
  assign imem_req_valid = (state_q == ST_RUN) && !redirect_valid && (credit_sum < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign instr_valid = (fifo_cnt_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr_data  = instr_valid ? data_mem[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 32'h0;
`ifdef IFU_ALIGN_CHECK_EN
  assign instr_fault = instr_valid ? fault_mem[rd_ptr_q] : 1'b0;
`else
  assign instr_fault = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      default: state_d = state_q;
    endcase
    if (redirect_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
      state_d = fault_redirect ? ST_FAULT : ST_RUN;
`else
      state_d = ST_RUN;
`endif
    end
  end

  // Outstanding-request accounting: a redirect turns every live request into a drop.
  always_comb begin
    live_d = live_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      live_d = '0;
      drop_d = drop_q + live_q + CW'(accept) - CW'(imem_rsp_valid);
    end else begin
      live_d = live_q + CW'(accept) - CW'(rsp_keep);
      drop_d = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
    end else begin
      live_q <= live_d;
      drop_q <= drop_d;
      if (redirect_valid)  fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      else if (accept)     fetch_pc_q <= fetch_pc_q + 32'd4;
    end
  end

  // Pending-PC tracker; every response pops it, kept or dropped, since responses are in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd_q <= '0;
      pend_wr_q <= '0;
    end else begin
      if (accept)         pend_wr_q <= pend_wr_q + AW'(1);
      if (imem_rsp_valid) pend_rd_q <= pend_rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_pc[pend_wr_q] <= fetch_pc_q;
  end

  // FIFO write port: either a kept response or the single fault entry of a misaligned redirect.
  assign fifo_we    = fault_redirect || rsp_keep;
  assign fifo_waddr = fault_redirect ? '0 : wr_ptr_q;
  assign fifo_wpc   = fault_redirect ? redirect_pc : pend_pc[pend_rd_q];
  assign fifo_wdata = fault_redirect ? NOP : imem_rsp_data;

  always_ff @(posedge clk) begin
    if (fifo_we) begin
      pc_mem[fifo_waddr]   <= fifo_wpc;
      data_mem[fifo_waddr] <= fifo_wdata;
`ifdef IFU_ALIGN_CHECK_EN
      fault_mem[fifo_waddr] <= fault_redirect;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= fault_redirect ? AW'(1) : '0;
      fifo_cnt_q <= fault_redirect ? CW'(1) : '0;
    end else begin
      if (rsp_keep) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(rsp_keep) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order instruction memory model.
// Memory returns data = ~addr so every delivered word is tied to its address.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc     = 0;
  int lat     = 1;
  int acc_cnt = 0;
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acts late in the low phase, after the main process has driven its inputs.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      pend_addr_q.delete();
      pend_due_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      acc_cnt        = 0;
    end else begin
      if (pend_due_q.size() > 0 && pend_due_q[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend_addr_q[0];
        void'(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr_q.push_back(imem_req_addr);
        pend_due_q.push_back(cyc + lat);
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic ready, input int l);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = ready;
    lat            = l;
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_instr_fault", 32'(instr_fault), 32'h0);
    rst = 1'b0;
    #1;
    check("boot_no_req", 32'(imem_req_valid), 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Streaming fetch, L=1, core always ready
    do_reset(1'b1, 1);
    tick();
    check("s_req_valid_first", 32'(imem_req_valid), 32'h1);
    check("s_req_addr_first", imem_req_addr, 32'h0);
    check("s_no_instr_c1", 32'(instr_valid), 32'h0);
    tick();
    check("s_req_addr_second", imem_req_addr, 32'h4);
    check("s_no_instr_c2", 32'(instr_valid), 32'h0);
    tick();
    check("s_instr_valid_first", 32'(instr_valid), 32'h1);
    check("s_pc0", instr_pc, 32'h0);
    check("s_data0", instr_data, 32'hFFFF_FFFF);
    check("s_fault0", 32'(instr_fault), 32'h0);
    check("s_req_addr_third", imem_req_addr, 32'h8);
    tick();
    check("s_pc4", instr_pc, 32'h4);
    check("s_data4", instr_data, 32'hFFFF_FFFB);
    tick();
    check("s_pc8", instr_pc, 32'h8);
    check("s_data8", instr_data, 32'hFFFF_FFF7);

    // Mid-operation reset, then core stalled: FIFO fills with exactly DEPTH requests
    do_reset(1'b0, 1);
    repeat (6) tick();
    check("f_req_stopped", 32'(imem_req_valid), 32'h0);
    check("f_instr_valid", 32'(instr_valid), 32'h1);
    check("f_head_pc", instr_pc, 32'h0);
    check("f_req_count", 32'(acc_cnt), 32'd4);
    tick();
    check("f_req_count_hold", 32'(acc_cnt), 32'd4);
    check("f_req_still_stopped", 32'(imem_req_valid), 32'h0);
    instr_ready = 1'b1;
    tick();
    check("f_pop_pc4", instr_pc, 32'h4);
    check("f_resume_valid", 32'(imem_req_valid), 32'h1);
    check("f_resume_addr", imem_req_addr, 32'h10);
    tick();
    check("f_pop_pc8", instr_pc, 32'h8);
    check("f_resume_addr2", imem_req_addr, 32'h14);
    tick();
    check("f_pop_pcC", instr_pc, 32'hC);
    tick();
    check("f_pc10", instr_pc, 32'h10);
    check("f_data10", instr_data, 32'hFFFF_FFEF);

    // L=3, redirect to 0x100 while three requests are outstanding
    do_reset(1'b1, 3);
    tick();
    check("l3_req_addr0", imem_req_addr, 32'h0);
    tick();
    tick();
    tick();
    check("l3_req_valid_c4", 32'(imem_req_valid), 32'h1);
    check("l3_req_addr_c4", imem_req_addr, 32'hC);
    check("l3_no_instr_c4", 32'(instr_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("l3_redirect_blocks_req", 32'(imem_req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("l3_new_req_valid", 32'(imem_req_valid), 32'h1);
    check("l3_new_req_addr", imem_req_addr, 32'h100);
    check("l3_no_stale_q1", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_no_stale", 32'(instr_valid), 32'h0);
    end
    tick();
    check("l3_first_pc", instr_pc, 32'h100);
    check("l3_first_data", instr_data, 32'hFFFF_FEFF);
    tick();
    check("l3_second_pc", instr_pc, 32'h104);

    // Redirect together with a response and a pop, FIFO nearly full
    do_reset(1'b0, 1);
    repeat (5) tick();
    check("rp_instr_valid", 32'(instr_valid), 32'h1);
    check("rp_head_pc", instr_pc, 32'h0);
    check("rp_req_stopped", 32'(imem_req_valid), 32'h0);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rp_fifo_flushed", 32'(instr_valid), 32'h0);
    check("rp_req_valid", 32'(imem_req_valid), 32'h1);
    check("rp_req_addr", imem_req_addr, 32'h200);
    tick();
    check("rp_still_empty", 32'(instr_valid), 32'h0);
    check("rp_req_addr2", imem_req_addr, 32'h204);
    tick();
    check("rp_first_pc", instr_pc, 32'h200);
    check("rp_first_data", instr_data, 32'hFFFF_FDFF);
    tick();
    check("rp_pc204", instr_pc, 32'h204);
    tick();
    check("rp_pc208", instr_pc, 32'h208);

    // Misaligned redirect to 0x102
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef IFU_ALIGN_CHECK_EN
    check("ma_fault_valid", 32'(instr_valid), 32'h1);
    check("ma_fault_flag", 32'(instr_fault), 32'h1);
    check("ma_fault_data", instr_data, 32'h0000_0013);
    check("ma_fault_pc", instr_pc, 32'h102);
    check("ma_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    tick();
    check("ma_fault_hold", 32'(instr_fault), 32'h1);
    check("ma_fault_pc_hold", instr_pc, 32'h102);
    check("ma_no_req_hold", 32'(imem_req_valid), 32'h0);
`else
    check("ma_no_instr", 32'(instr_valid), 32'h0);
    check("ma_req_valid", 32'(imem_req_valid), 32'h1);
    check("ma_req_addr", imem_req_addr, 32'h100);
    tick();
    check("ma_req_addr2", imem_req_addr, 32'h104);
    check("ma_no_instr2", 32'(instr_valid), 32'h0);
    tick();
    check("ma_pc", instr_pc, 32'h100);
    check("ma_data", instr_data, 32'hFFFF_FEFF);
    check("ma_fault_clear", 32'(instr_fault), 32'h0);
`endif
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rs_req_valid", 32'(imem_req_valid), 32'h1);
    check("rs_req_addr", imem_req_addr, 32'h200);
    check("rs_fifo_empty", 32'(instr_valid), 32'h0);
    check("rs_fault_zero", 32'(instr_fault), 32'h0);
    tick();
    check("rs_still_empty", 32'(instr_valid), 32'h0);
    tick();
    check("rs_pc", instr_pc, 32'h200);
    check("rs_fault", 32'(instr_fault), 32'h0);

    // Fetch PC wraps past 0xFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("w_req_addr_fff8", imem_req_addr, 32'hFFFF_FFF8);
    check("w_empty", 32'(instr_valid), 32'h0);
    tick();
    check("w_req_addr_fffc", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("w_req_addr_wrap", imem_req_addr, 32'h0000_0000);
    check("w_pc_fff8", instr_pc, 32'hFFFF_FFF8);
    check("w_data_fff8", instr_data, 32'h0000_0007);
    tick();
    check("w_pc_fffc", instr_pc, 32'hFFFF_FFFC);
    check("w_data_fffc", instr_data, 32'h0000_0003);
    tick();
    check("w_pc_0", instr_pc, 32'h0);
    check("w_data_0", instr_data, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
